ram8_arbiter: RTL

Two-port round-robin arbiter that shares a single RAM8 (8 × 16-bit words, write on clock edge, combinational read) between two requesters, e.g. the CPU data port and a DMA/debug port. Each transaction is one read or one write of one word, completed with a one-cycle `ack` pulse. The block drives RAM8's `in`/`addr`/`ld` and samples its `out`, and is the only agent allowed to write the RAM.

---
 rtl/ram8_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 23 ++
 rtl/ram8_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/ram8_arb_pkg.sv
// Shared types and default widths for the two-port RAM8 arbiter.
// Port index is a single bit: 0 = requester 0, 1 = requester 1.
package ram8_arb_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } arb_state_t;

   typedef logic port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last. Purely combinational.
module rr_arb2
   import ram8_arb_pkg::*;
(
   input  logic  req0,
   input  logic  req1,
   input  port_t last,
   output logic  grant_valid,
   output port_t grant_idx
);

   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = 1'b0;
      if (req0 && req1) begin
         grant_idx = ~last;
      end else if (req1) begin
         grant_idx = 1'b1;
      end
   end

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one RAM8 (write on edge, combinational read) between two requesters,
// one word per transaction, alternating grants when both keep requesting.
module ram8_arbiter
   import ram8_arb_pkg::*;
#(
   parameter int DATA_W = ram8_arb_pkg::DATA_W,
   parameter int ADDR_W = ram8_arb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] ram_in,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_ld,
   input  logic [DATA_W-1:0] ram_out,
   output arb_state_t        state_dbg
);

   // Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
   // until its one-cycle ackN. reqN still high during ackN is a new transaction.

   arb_state_t        state_q, state_d;
   port_t             last_q;
   logic              ack0_q, ack1_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic              grant_valid;
   port_t             grant_idx;
   logic              grant;

   rr_arb2 u_pick (
      .req0        (req0),
      .req1        (req1),
      .last        (last_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Reset gates the grant so no write can commit in a reset cycle.
   always_comb begin
      state_d  = state_q;
      grant    = 1'b0;
      ram_ld   = 1'b0;
      ram_addr = '0;
      ram_in   = '0;
      case (state_q)
         IDLE: begin
            if (grant_valid && !reset) begin
               grant    = 1'b1;
               state_d  = ACK;
               ram_addr = grant_idx ? addr1  : addr0;
               ram_in   = grant_idx ? wdata1 : wdata0;
               ram_ld   = grant_idx ? we1    : we0;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q <= state_d;
         ack0_q  <= grant && !grant_idx;
         ack1_q  <= grant &&  grant_idx;
         if (grant) begin
            last_q <= grant_idx;
         end
         if (grant && !ram_ld) begin
            if (grant_idx) begin
               rdata1_q <= ram_out;
            end else begin
               rdata0_q <= ram_out;
            end
         end
      end
   end

   // A reset landing on the ack cycle withdraws the pending ack.
   assign ack0      = ack0_q & ~reset;
   assign ack1      = ack1_q & ~reset;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign state_dbg = state_q;

endmodule
